// File: rtl/lsu_mem_stage.sv
// Load/store memory stage: one valid/ack data-memory transaction per load/store, with lane alignment and extension.
// Optional misaligned-access trap is enabled by defining LSU_MISALIGN_TRAP_EN.
module lsu_mem_stage #(
  parameter int W       = 32,
  parameter int TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  input  logic         req_we,
  input  logic [1:0]   req_size,
  input  logic         req_unsigned,
  input  logic [W-1:0] req_addr,
  input  logic [W-1:0] req_wdata,
  output logic         busy,
  output logic         rsp_valid,
  output logic [W-1:0] rsp_rdata,
  output logic         misalign,
  output logic         err,
  output logic         mem_req,
  output logic         mem_we,
  output logic [W-1:0] mem_addr,
  output logic [3:0]   mem_wstrb,
  output logic [31:0]  mem_wdata,
  input  logic         mem_ack,
  input  logic [31:0]  mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  logic [7:0]  cnt;
  logic        we_q;
  logic        uns_q;
  logic [1:0]  size_q;
  logic [1:0]  alo_q;
  logic [3:0]  strb_d;
  logic [31:0] wdata_d;
  logic        mis_d;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_d;

  assign busy = (state == REQ) || ((state == IDLE) && req_valid);

  always_comb begin
    strb_d  = 4'b0000;
    wdata_d = 32'h0;
    if (req_we) begin
      case (req_size)
        2'b00: begin
          strb_d  = 4'b0001 << req_addr[1:0];
          wdata_d = {4{req_wdata[7:0]}};
        end
        2'b01: begin
          strb_d  = 4'b0011 << {req_addr[1], 1'b0};
          wdata_d = {2{req_wdata[15:0]}};
        end
        default: begin
          strb_d  = 4'b1111;
          wdata_d = req_wdata[31:0];
        end
      endcase
    end
  end

  always_comb begin
`ifdef LSU_MISALIGN_TRAP_EN
    mis_d = ((req_size == 2'b01) && req_addr[0]) ||
            (req_size[1] && (req_addr[1:0] != 2'b00));
`else
    mis_d = 1'b0;
`endif
  end

  // Extraction uses the lane bits latched at request time, not the live address.
  always_comb begin
    byte_sel = 8'h0;
    case (alo_q)
      2'd0:    byte_sel = mem_rdata[7:0];
      2'd1:    byte_sel = mem_rdata[15:8];
      2'd2:    byte_sel = mem_rdata[23:16];
      default: byte_sel = mem_rdata[31:24];
    endcase
    half_sel = alo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_q)
      2'b00:   load_d = uns_q ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      2'b01:   load_d = uns_q ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: load_d = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      we_q      <= 1'b0;
      uns_q     <= 1'b0;
      size_q    <= 2'b00;
      alo_q     <= 2'b00;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      misalign  <= 1'b0;
      err       <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wstrb <= 4'b0000;
      mem_wdata <= 32'h0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q   <= req_we;
            uns_q  <= req_unsigned;
            size_q <= req_size;
            alo_q  <= req_addr[1:0];
            if (mis_d) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              misalign  <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              state     <= REQ;
              cnt       <= 8'd0;
              mem_req   <= 1'b1;
              mem_we    <= req_we;
              mem_addr  <= {req_addr[W-1:2], 2'b00};
              mem_wstrb <= strb_d;
              mem_wdata <= wdata_d;
            end
          end
        end
        REQ: begin
          // An ack in the final counted cycle still wins over the timeout.
          if (mem_ack) begin
            state     <= RESP;
            mem_req   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= we_q ? '0 : load_d;
          end else if (cnt == CNT_LAST) begin
            state     <= RESP;
            mem_req   <= 1'b0;
            rsp_valid <= 1'b1;
            err       <= 1'b1;
            rsp_rdata <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        RESP: begin
          state     <= IDLE;
          err       <= 1'b0;
          misalign  <= 1'b0;
          rsp_rdata <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed self-checking bench for lsu_mem_stage, built with a short TIMEOUT so the abort path is reachable.
module tb_lsu_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        busy;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        misalign;
  logic        err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int n_assert = 0;
  int n_fail   = 0;

  lsu_mem_stage #(.W(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .busy(busy), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .misalign(misalign), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wdata);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
  endtask

  task automatic endAccess();
    req_valid = 1'b0;
    mem_ack   = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_busy"},      busy,      0);
    checkOutput({tag, "_rsp_valid"}, rsp_valid, 0);
    checkOutput({tag, "_rsp_rdata"}, rsp_rdata, 0);
    checkOutput({tag, "_misalign"},  misalign,  0);
    checkOutput({tag, "_err"},       err,       0);
    checkOutput({tag, "_mem_req"},   mem_req,   0);
    checkOutput({tag, "_mem_we"},    mem_we,    0);
    checkOutput({tag, "_mem_addr"},  mem_addr,  0);
    checkOutput({tag, "_mem_wstrb"}, mem_wstrb, 0);
    checkOutput({tag, "_mem_wdata"}, mem_wdata, 0);
  endtask

  // Zero-wait load: request, one REQ cycle with ack, then the response cycle.
  task automatic simpleLoad(input string tag, input logic [1:0] size, input logic uns,
                            input logic [31:0] addr, input logic [31:0] rdata,
                            input logic [31:0] exp_addr, input logic [31:0] exp);
    applyStimulus(1'b0, size, uns, addr, 32'h0);
    tick();
    checkOutput({tag, "_mem_req"},   mem_req,   1);
    checkOutput({tag, "_mem_addr"},  mem_addr,  exp_addr);
    checkOutput({tag, "_mem_wstrb"}, mem_wstrb, 0);
    mem_ack   = 1'b1;
    mem_rdata = rdata;
    tick();
    checkOutput({tag, "_rsp_valid"}, rsp_valid, 1);
    checkOutput({tag, "_rsp_rdata"}, rsp_rdata, exp);
    checkOutput({tag, "_err"},       err,       0);
    endAccess();
    tick();
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
    tick();
    tick();
    checkAllZero("reset");
    rst = 1'b0;
    tick();

    // Word store, zero-wait memory.
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF);
    #1;
    checkOutput("sw_c0_busy", busy, 1);
    checkOutput("sw_c0_mem_req", mem_req, 0);
    tick();
    checkOutput("sw_c1_mem_req", mem_req, 1);
    checkOutput("sw_c1_busy", busy, 1);
    checkOutput("sw_c1_mem_we", mem_we, 1);
    checkOutput("sw_c1_mem_addr", mem_addr, 32'h100);
    checkOutput("sw_c1_wstrb", mem_wstrb, 4'b1111);
    checkOutput("sw_c1_wdata", mem_wdata, 32'hDEADBEEF);
    checkOutput("sw_c1_rsp_valid", rsp_valid, 0);
    mem_ack = 1'b1;
    tick();
    checkOutput("sw_c2_rsp_valid", rsp_valid, 1);
    checkOutput("sw_c2_busy", busy, 0);
    checkOutput("sw_c2_mem_req", mem_req, 0);
    checkOutput("sw_c2_rsp_rdata", rsp_rdata, 0);
    endAccess();
    tick();
    checkOutput("sw_c3_rsp_valid", rsp_valid, 0);

    // LB @0x103 with ack after two REQ cycles.
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h103, 32'h0);
    tick();
    checkOutput("lb_c1_mem_req", mem_req, 1);
    checkOutput("lb_c1_mem_we", mem_we, 0);
    checkOutput("lb_c1_mem_addr", mem_addr, 32'h100);
    checkOutput("lb_c1_wstrb", mem_wstrb, 0);
    tick();
    checkOutput("lb_c2_mem_req", mem_req, 1);
    checkOutput("lb_c2_rsp_valid", rsp_valid, 0);
    mem_ack   = 1'b1;
    mem_rdata = 32'h80112233;
    tick();
    checkOutput("lb_c3_rsp_valid", rsp_valid, 1);
    checkOutput("lb_c3_rsp_rdata", rsp_rdata, 32'hFFFFFF80);
    endAccess();
    tick();

    simpleLoad("lbu", 2'b00, 1'b1, 32'h103, 32'h80112233, 32'h100, 32'h00000080);
    simpleLoad("lh_hi", 2'b01, 1'b0, 32'h102, 32'h7FFF0000, 32'h100, 32'h00007FFF);
    simpleLoad("lh_lo", 2'b01, 1'b0, 32'h100, 32'h12348765, 32'h100, 32'hFFFF8765);

    // Half store into the upper lane.
    applyStimulus(1'b1, 2'b01, 1'b0, 32'h102, 32'h1234ABCD);
    tick();
    checkOutput("sh_wstrb", mem_wstrb, 4'b1100);
    checkOutput("sh_wdata", mem_wdata, 32'hABCDABCD);
    mem_ack = 1'b1;
    tick();
    checkOutput("sh_rsp_valid", rsp_valid, 1);
    endAccess();
    tick();

    // Ack withheld: four REQ cycles, then an error response; late ack ignored.
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h104, 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("to_mem_req", mem_req, 1);
      checkOutput("to_rsp_valid_low", rsp_valid, 0);
    end
    tick();
    checkOutput("to_rsp_valid", rsp_valid, 1);
    checkOutput("to_err", err, 1);
    checkOutput("to_rsp_rdata", rsp_rdata, 0);
    checkOutput("to_mem_req_drop", mem_req, 0);
    req_valid = 1'b0;
    mem_ack   = 1'b1;
    tick();
    checkOutput("late_ack_rsp_valid", rsp_valid, 0);
    checkOutput("late_ack_mem_req", mem_req, 0);
    checkOutput("late_ack_busy", busy, 0);
    tick();
    checkOutput("late_ack_rsp_valid2", rsp_valid, 0);
    mem_ack = 1'b0;

    // Ack arriving in the last counted REQ cycle beats the timeout.
    applyStimulus(1'b0, 2'b01, 1'b1, 32'h106, 32'h0);
    for (int i = 0; i < 3; i++) tick();
    tick();
    checkOutput("race_mem_req", mem_req, 1);
    mem_ack   = 1'b1;
    mem_rdata = 32'hF00D1234;
    tick();
    checkOutput("race_rsp_valid", rsp_valid, 1);
    checkOutput("race_err", err, 0);
    checkOutput("race_rsp_rdata", rsp_rdata, 32'h0000F00D);
    endAccess();
    tick();

    // Misaligned word load.
`ifdef LSU_MISALIGN_TRAP_EN
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h101, 32'h0);
    #1;
    checkOutput("mis_c0_busy", busy, 1);
    tick();
    checkOutput("mis_rsp_valid", rsp_valid, 1);
    checkOutput("mis_misalign", misalign, 1);
    checkOutput("mis_mem_req", mem_req, 0);
    checkOutput("mis_rsp_rdata", rsp_rdata, 0);
    endAccess();
    tick();
`else
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h101, 32'h0);
    tick();
    checkOutput("mis_mem_addr", mem_addr, 32'h100);
    mem_ack   = 1'b1;
    mem_rdata = 32'hCAFEF00D;
    tick();
    checkOutput("mis_rsp_valid", rsp_valid, 1);
    checkOutput("mis_misalign", misalign, 0);
    checkOutput("mis_rsp_rdata", rsp_rdata, 32'hCAFEF00D);
    endAccess();
    tick();
`endif

    // Reset while a request is outstanding.
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h200, 32'h11223344);
    tick();
    checkOutput("rstreq_mem_req", mem_req, 1);
    rst       = 1'b1;
    req_valid = 1'b0;
    tick();
    checkAllZero("rstreq");
    rst     = 1'b0;
    mem_ack = 1'b1;
    tick();
    checkOutput("rstreq_late_ack", rsp_valid, 0);
    checkOutput("rstreq_late_mem_req", mem_req, 0);
    mem_ack = 1'b0;

    // Byte store after reset completes normally.
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h201, 32'h000000A5);
    tick();
    checkOutput("sb_mem_addr", mem_addr, 32'h200);
    checkOutput("sb_wstrb", mem_wstrb, 4'b0010);
    checkOutput("sb_wdata", mem_wdata, 32'hA5A5A5A5);
    mem_ack = 1'b1;
    tick();
    checkOutput("sb_rsp_valid", rsp_valid, 1);
    checkOutput("sb_err", err, 0);
    endAccess();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
